// File: rtl/block_serializer_pkg.sv
// Shared widths, FSM state type and the 64-bit bit-reversal helper for block_serializer.
package block_serializer_pkg;

    localparam int unsigned BLOCK_W         = 64;
    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned BYTES_PER_BLOCK = 8;
    localparam int unsigned IDX_W           = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic logic [BLOCK_W-1:0] bit_reverse64(input logic [BLOCK_W-1:0] v);
        logic [BLOCK_W-1:0] r;
        r = '0;
        for (int i = 0; i < BLOCK_W; i++) begin
            r[i] = v[BLOCK_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/block_serializer_if.sv
// Block-in / byte-out handshake bundle for block_serializer.
interface block_serializer_if;
    import block_serializer_pkg::*;

    logic [BLOCK_W-1:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic [BYTE_W-1:0]  out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

endinterface

// File: rtl/block_serializer_bit_reverse64.sv
// Pure combinational full 64-bit bit reversal (rev[i] = blk[63-i]).
module bit_reverse64
    import block_serializer_pkg::*;
(
    input  logic [BLOCK_W-1:0] blk,
    output logic [BLOCK_W-1:0] rev
);

    assign rev = block_serializer_pkg::bit_reverse64(blk);

endmodule

// File: rtl/block_serializer.sv
// Serializes 64-bit blocks into 8 bytes on a valid/ready stream.
// Optional feature macro: BLOCK_SERIALIZER_BITREV_EN (bit-reverse each block before sending).
module block_serializer
    import block_serializer_pkg::*;
#(
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    block_serializer_if.slave bus,
    output logic [CNT_W-1:0] blk_count,
    output logic             busy
);

    state_t             state;
    logic [BLOCK_W-1:0] shiftReg;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   blkCount;
    logic               outValid;
    logic               outLast;
    logic [BLOCK_W-1:0] loadVal;
    logic [BLOCK_W-1:0] shifted;

`ifdef BLOCK_SERIALIZER_BITREV_EN
    bit_reverse64 uRev (
        .blk (bus.in_data),
        .rev (loadVal)
    );
`else
    assign loadVal = bus.in_data;
`endif

    // Next byte always sits at the end of the shift register facing the output.
    assign shifted = MSB_FIRST ? {shiftReg[BLOCK_W-BYTE_W-1:0], {BYTE_W{1'b0}}}
                               : {{BYTE_W{1'b0}}, shiftReg[BLOCK_W-1:BYTE_W]};

    assign bus.out_data  = MSB_FIRST ? shiftReg[BLOCK_W-1 -: BYTE_W] : shiftReg[BYTE_W-1:0];
    assign bus.out_valid = outValid;
    assign bus.out_last  = outLast;
    assign bus.in_ready  = !rst && ((state == IDLE) || (outValid && outLast && bus.out_ready));
    assign blk_count     = blkCount;
    assign busy          = (state == SEND);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shiftReg <= '0;
            idx      <= '0;
            blkCount <= '0;
            outValid <= 1'b0;
            outLast  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        shiftReg <= loadVal;
                        idx      <= '0;
                        outValid <= 1'b1;
                        outLast  <= 1'b0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (bus.out_ready) begin
                        if (outLast) begin
                            blkCount <= blkCount + CNT_W'(1);
                            idx      <= '0;
                            outLast  <= 1'b0;
                            // A block offered on the final byte follows with no bubble.
                            if (bus.in_valid) begin
                                shiftReg <= loadVal;
                            end else begin
                                shiftReg <= shifted;
                                outValid <= 1'b0;
                                state    <= IDLE;
                            end
                        end else begin
                            shiftReg <= shifted;
                            idx      <= idx + IDX_W'(1);
                            outLast  <= (idx == IDX_W'(BYTES_PER_BLOCK - 2));
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    outValid <= 1'b0;
                    outLast  <= 1'b0;
                end
            endcase
        end
    end

endmodule
